// File: rtl/icache_pkg.sv
// icache_pkg: shared line geometry and FSM state type for the set-associative instruction cache
package icache_pkg;
   localparam int LINE_BITS     = 256;
   localparam int OFFSET_BITS   = 5;
   localparam int WORD_SEL_BITS = 3;
   typedef enum logic [1:0] {IDLE, FILL, FLUSH} icache_state_t;
endpackage

// File: rtl/icache_plru.sv
// icache_plru: tree pseudo-LRU next-state and victim for one set
module icache_plru #(
   parameter int NUM_WAYS = 2,
   parameter int WW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
   parameter int PW = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1
) (
   input  logic [PW-1:0] plru_i,
   input  logic [WW-1:0] way_i,
   output logic [PW-1:0] plru_o,
   output logic [WW-1:0] victim_o
);
   // Each tree bit points toward the side that should be evicted next.
   if (NUM_WAYS == 4) begin : g_four
      assign plru_o   = {way_i[1] ? ~way_i[0] : plru_i[2], way_i[1] ? plru_i[1] : ~way_i[0], ~way_i[1]};
      assign victim_o = plru_i[0] ? {1'b1, plru_i[2]} : {1'b0, plru_i[1]};
   end else if (NUM_WAYS == 2) begin : g_two
      assign plru_o   = ~way_i;
      assign victim_o = plru_i;
   end else begin : g_one
      assign plru_o   = plru_i;
      assign victim_o = '0;
   end
endmodule

// File: rtl/icache_sa.sv
// icache_sa: read-only N-way set-associative instruction cache with PLRU, flush and perf counters
module icache_sa
   import icache_pkg::*;
#(
   parameter int NUM_SETS = 8,
   parameter int NUM_WAYS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 read_a,
   input  logic [31:0]          address_a,
   output logic [31:0]          rdata_a,
   output logic                 resp_a,
   input  logic                 flush,
   output logic                 pmem_read_a,
   output logic [31:0]          pmem_addr_a,
   input  logic [LINE_BITS-1:0] pmem_rdata_a,
   input  logic                 pmem_resp_a,
   output logic [31:0]          hit_count,
   output logic [31:0]          miss_count
);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 32 - OFFSET_BITS - IDX_W;
   localparam int LA_W  = 32 - OFFSET_BITS;
   localparam int WW    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
   localparam int PW    = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

   icache_state_t        state_q, state_d;
   logic                 pend_q;
   logic [LA_W-1:0]      line_q;
   logic [31:0]          hit_q, miss_q;
   logic                 valid_q [NUM_SETS][NUM_WAYS];
   logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
   logic [LINE_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
   logic [PW-1:0]        plru_q  [NUM_SETS];

   logic [IDX_W-1:0] req_idx, fill_idx, plru_idx;
   logic [TAG_W-1:0] req_tag, fill_tag;
   logic [WW-1:0]    hit_way, inv_way, victim, plru_victim, acc_way;
   logic [PW-1:0]    plru_nxt;
   logic             hit, inv, pending, is_idle, is_fill, do_hit, do_miss, fill_done;
   logic             unused_addr;

   assign unused_addr = ^address_a[1:0];
   assign req_idx     = address_a[OFFSET_BITS +: IDX_W];
   assign req_tag     = address_a[31 -: TAG_W];
   assign fill_idx    = line_q[IDX_W-1:0];
   assign fill_tag    = line_q[LA_W-1 -: TAG_W];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      inv     = 1'b0;
      inv_way = '0;
      for (int w = 0; w < NUM_WAYS; w++)
         if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
            hit     = 1'b1;
            hit_way = WW'(w);
         end
      for (int w = NUM_WAYS - 1; w >= 0; w--)
         if (!valid_q[fill_idx][w]) begin
            inv     = 1'b1;
            inv_way = WW'(w);
         end
   end

   // A flush pulse seen in IDLE already outranks a request that same cycle.
   assign pending   = flush | pend_q;
   assign is_idle   = state_q == IDLE;
   assign is_fill   = state_q == FILL;
   assign do_hit    = is_idle && !pending && read_a && hit;
   assign do_miss   = is_idle && !pending && read_a && !hit;
   assign fill_done = is_fill && pmem_resp_a;
   assign victim    = inv ? inv_way : plru_victim;
   assign plru_idx  = is_fill ? fill_idx : req_idx;
   assign acc_way   = is_fill ? victim : hit_way;

   icache_plru #(.NUM_WAYS(NUM_WAYS), .WW(WW), .PW(PW)) u_plru (
      .plru_i   (plru_q[plru_idx]),
      .way_i    (acc_way),
      .plru_o   (plru_nxt),
      .victim_o (plru_victim)
   );

   always_comb
      state_d = is_idle ? (pending ? FLUSH : do_miss ? FILL : IDLE)
              : is_fill ? (pmem_resp_a ? IDLE : FILL) : IDLE;

   assign resp_a      = do_hit;
   assign rdata_a     = do_hit ? data_q[req_idx][hit_way][{address_a[4:2], 5'b0} +: 32] : '0;
   assign pmem_read_a = is_fill;
   assign pmem_addr_a = is_fill ? {line_q, 5'b0} : '0;
   assign hit_count   = hit_q;
   assign miss_count  = miss_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= 1'b0;
         line_q  <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            plru_q[s] <= '0;
            for (int w = 0; w < NUM_WAYS; w++) valid_q[s][w] <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         pend_q  <= (state_q == FLUSH) ? flush : pending;
         if (do_hit && !(&hit_q)) hit_q <= hit_q + 32'd1;
         if (do_miss) begin
            line_q <= address_a[31:OFFSET_BITS];
            if (!(&miss_q)) miss_q <= miss_q + 32'd1;
         end
         if (do_hit) plru_q[req_idx] <= plru_nxt;
         if (fill_done) begin
            valid_q[fill_idx][victim] <= 1'b1;
            plru_q[fill_idx]          <= plru_nxt;
         end
         if (state_q == FLUSH)
            for (int s = 0; s < NUM_SETS; s++) begin
               plru_q[s] <= '0;
               for (int w = 0; w < NUM_WAYS; w++) valid_q[s][w] <= 1'b0;
            end
      end
   end

   // Tag and line storage needs no reset: valid bits gate every use.
   always_ff @(posedge clk)
      if (fill_done) begin
         tag_q[fill_idx][victim]  <= fill_tag;
         data_q[fill_idx][victim] <= pmem_rdata_a;
      end
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed self-checking bench for icache_sa (8 sets, 2 ways)
module tb_icache_sa;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         read_a = 1'b0;
   logic [31:0]  address_a = '0;
   logic [31:0]  rdata_a;
   logic         resp_a;
   logic         flush = 1'b0;
   logic         pmem_read_a;
   logic [31:0]  pmem_addr_a;
   logic [255:0] pmem_rdata_a = '0;
   logic         pmem_resp_a = 1'b0;
   logic [31:0]  hit_count, miss_count;
   int           checks = 0;
   int           errors = 0;
   logic [255:0] l40, l140, l240;

   icache_sa #(.NUM_SETS(8), .NUM_WAYS(2)) dut (
      .clk(clk), .rst_n(rst_n), .read_a(read_a), .address_a(address_a),
      .rdata_a(rdata_a), .resp_a(resp_a), .flush(flush),
      .pmem_read_a(pmem_read_a), .pmem_addr_a(pmem_addr_a),
      .pmem_rdata_a(pmem_rdata_a), .pmem_resp_a(pmem_resp_a),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   function automatic logic [255:0] mk(input logic [31:0] b);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = b + 32'(k);
      return l;
   endfunction

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic hit_read(input logic [31:0] a, input logic [31:0] exp);
      read_a = 1'b1;
      address_a = a;
      #1;
      chk("hit_resp", 32'(resp_a), 32'd1);
      chk("hit_rdata", rdata_a, exp);
      chk("hit_no_pmem", 32'(pmem_read_a), 32'd0);
      tick;
      read_a = 1'b0;
   endtask

   task automatic miss_read(input logic [31:0] a, input logic [255:0] line, input int lat, input logic [31:0] exp);
      read_a = 1'b1;
      address_a = a;
      #1;
      chk("miss_no_resp", 32'(resp_a), 32'd0);
      chk("miss_pmem_idle", 32'(pmem_read_a), 32'd0);
      tick;
      chk("fill_pmem_read", 32'(pmem_read_a), 32'd1);
      chk("fill_pmem_addr", pmem_addr_a, a & 32'hFFFF_FFE0);
      repeat (lat - 1) tick;
      pmem_resp_a = 1'b1;
      pmem_rdata_a = line;
      #1;
      chk("fill_no_resp", 32'(resp_a), 32'd0);
      tick;
      pmem_resp_a = 1'b0;
      pmem_rdata_a = '0;
      #1;
      chk("retry_resp", 32'(resp_a), 32'd1);
      chk("retry_rdata", rdata_a, exp);
      chk("retry_pmem_low", 32'(pmem_read_a), 32'd0);
      tick;
      read_a = 1'b0;
   endtask

   initial begin
      l40 = mk(32'h1111_0000);
      l40[63:32] = 32'hDEAD_BEEF;
      l140 = mk(32'h2222_0000);
      l240 = mk(32'h3333_0000);
      tick;
      tick;
      rst_n = 1'b1;
      #1;
      chk("rst_resp", 32'(resp_a), 32'd0);
      chk("rst_rdata", rdata_a, 32'd0);
      chk("rst_pmem_read", 32'(pmem_read_a), 32'd0);
      chk("rst_pmem_addr", pmem_addr_a, 32'd0);
      chk("rst_hit", hit_count, 32'd0);
      chk("rst_miss", miss_count, 32'd0);
      // cold miss, 3-cycle memory
      miss_read(32'h44, l40, 3, 32'hDEAD_BEEF);
      chk("cold_miss_cnt", miss_count, 32'd1);
      chk("cold_hit_cnt", hit_count, 32'd1);
      hit_read(32'h48, 32'h1111_0002);
      chk("same_line_hit_cnt", hit_count, 32'd2);
      // PLRU: set 2 holds 0x040 and 0x140, touch 0x040, then 0x240 evicts 0x140
      hit_read(32'h40, 32'h1111_0000);
      miss_read(32'h140, l140, 2, 32'h2222_0000);
      hit_read(32'h40, 32'h1111_0000);
      miss_read(32'h240, l240, 1, 32'h3333_0000);
      hit_read(32'h40, 32'h1111_0000);
      miss_read(32'h140, l140, 1, 32'h2222_0000);
      chk("plru_miss_cnt", miss_count, 32'd4);
      chk("plru_hit_cnt", hit_count, 32'd8);
      // flush after fill
      flush = 1'b1;
      #1;
      chk("flush_pulse_resp", 32'(resp_a), 32'd0);
      tick;
      flush = 1'b0;
      read_a = 1'b1;
      address_a = 32'h44;
      #1;
      chk("flush_cycle_resp", 32'(resp_a), 32'd0);
      chk("flush_cycle_pmem", 32'(pmem_read_a), 32'd0);
      tick;
      miss_read(32'h44, l40, 1, 32'hDEAD_BEEF);
      chk("flush_miss_cnt", miss_count, 32'd5);
      // flush during fill
      read_a = 1'b1;
      address_a = 32'h140;
      tick;
      chk("ff_fill", 32'(pmem_read_a), 32'd1);
      flush = 1'b1;
      tick;
      flush = 1'b0;
      pmem_resp_a = 1'b1;
      pmem_rdata_a = l140;
      tick;
      pmem_resp_a = 1'b0;
      pmem_rdata_a = '0;
      #1;
      chk("ff_idle_pend_resp", 32'(resp_a), 32'd0);
      chk("ff_idle_pmem", 32'(pmem_read_a), 32'd0);
      tick;
      #1;
      chk("ff_flush_resp", 32'(resp_a), 32'd0);
      tick;
      miss_read(32'h140, l140, 1, 32'h2222_0000);
      chk("ff_miss_cnt", miss_count, 32'd7);
      chk("ff_hit_cnt", hit_count, 32'd10);
      // reset mid-fill, then a late response must be ignored
      read_a = 1'b1;
      address_a = 32'h244;
      tick;
      chk("rf_fill", 32'(pmem_read_a), 32'd1);
      chk("rf_addr", pmem_addr_a, 32'h240);
      rst_n = 1'b0;
      tick;
      chk("rf_pmem_drop", 32'(pmem_read_a), 32'd0);
      chk("rf_hit_zero", hit_count, 32'd0);
      chk("rf_miss_zero", miss_count, 32'd0);
      rst_n = 1'b1;
      read_a = 1'b0;
      pmem_resp_a = 1'b1;
      pmem_rdata_a = l240;
      tick;
      pmem_resp_a = 1'b0;
      pmem_rdata_a = '0;
      chk("late_resp_miss", miss_count, 32'd0);
      miss_read(32'h244, l240, 2, 32'h3333_0001);
      chk("rf_reread_miss", miss_count, 32'd1);
      chk("rf_reread_hit", hit_count, 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
